// File: rtl/datapath_pkg.sv
// datapath_pkg: shared types and default widths for the pipelined datapath.
//   alu_op_e    - 4-bit ALU operation codes
//   fsm_state_e - issue FSM states (IDLE, MUL)
//   DEF_*       - default parameter values for datapath_pipe
package datapath_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_NREGS     = 8;
    localparam int DEF_MEM_DEPTH = 256;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_NOTA = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLT  = 4'b1001,
        ALU_INC  = 4'b1010,
        ALU_PASB = 4'b1011,
        ALU_MUL  = 4'b1100
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul: shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i        - load operands a_i/b_i and begin
//   done_o         - high during the last busy cycle; product_o is valid then
//   product_o      - low DATA_W bits of a_i * b_i
// A start at edge N gives done_o during the cycle ending at edge N+DATA_W,
// so the caller can capture the product on exactly that edge.
module alu_iter_mul #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic [DATA_W-1:0] acc_d;

    // Partial sum including the current bit; on the last cycle this is the
    // final product, which saves a cycle of latency.
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done_o) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/datapath_pipe.sv
// datapath_pipe: register file + ALU + data memory with an EX/WB pipeline,
// valid/ready issue handshake and an iterative multiplier.
// Ports:
//   clock, reset (async, active-high)
//   in_valid/in_ready          - issue handshake (transfer when both high)
//   rs_addr, rt_addr, rd_addr  - register selects
//   imm_data, imm_sel          - immediate and operand-B select
//   alu_sel                    - ALU operation (datapath_pkg::alu_op_e)
//   rf_write, mem_write, mem_sel - write-back controls
//   zero_flag, pos_flag        - flags of the last committed result
//   dbg_addr/dbg_data          - combinational read of committed RF state
// Build option: define DATAPATH_FWD_EN to bypass WB data to issuing operands;
// without it a RAW hazard against WB stalls issue for one cycle.
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int NREGS     = DEF_NREGS,
    parameter  int MEM_DEPTH = DEF_MEM_DEPTH,
    localparam int ADDR_W    = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] imm_data,
    input  logic              imm_sel,
    input  logic [3:0]        alu_sel,
    input  logic              rf_write,
    input  logic              mem_write,
    input  logic              mem_sel,
    output logic              zero_flag,
    output logic              pos_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int MEM_AW  = $clog2(MEM_DEPTH);
    localparam int SHAMT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] rf_q  [NREGS];
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // EX/WB pipeline register
    logic              ex_valid_q, ex_rf_write_q, ex_mem_write_q, ex_mem_sel_q;
    logic [ADDR_W-1:0] ex_rd_q;
    logic [DATA_W-1:0] ex_result_q, ex_store_q;
    logic              zero_q, pos_q;

    // Issue FSM and the control fields parked while the multiplier runs
    fsm_state_e        state_q;
    logic [ADDR_W-1:0] mul_rd_q;
    logic              mul_rf_write_q, mul_mem_write_q, mul_mem_sel_q;
    logic [DATA_W-1:0] mul_store_q;

    // ---------------- write-back stage ----------------
    logic [MEM_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_rf_we;

    assign wb_addr  = ex_result_q[MEM_AW-1:0];
    assign wb_data  = ex_mem_sel_q ? mem_q[wb_addr] : ex_result_q;
    assign wb_rf_we = ex_valid_q && ex_rf_write_q;

    // ---------------- operand read / hazard ----------------
    logic              hit_a, hit_b, hazard;
    logic [DATA_W-1:0] rs_val, rt_val, op_a, op_b;

    assign hit_a = wb_rf_we && (ex_rd_q == rs_addr);
    assign hit_b = wb_rf_we && (ex_rd_q == rt_addr);

`ifdef DATAPATH_FWD_EN
    assign rs_val = hit_a ? wb_data : rf_q[rs_addr];
    assign rt_val = hit_b ? wb_data : rf_q[rt_addr];
    assign hazard = 1'b0;
`else
    // The RF has no write-through, so hold issue until WB has landed.
    assign rs_val = rf_q[rs_addr];
    assign rt_val = rf_q[rt_addr];
    assign hazard = in_valid && (hit_a || hit_b);
`endif

    assign op_a = rs_val;
    assign op_b = imm_sel ? imm_data : rt_val;

    // ---------------- ALU ----------------
    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_res;
    logic [SHAMT_W-1:0] shamt;

    assign alu_op = alu_op_e'(alu_sel);
    assign shamt  = op_b[SHAMT_W-1:0];

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        alu_res = op_a;
        case (alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOTA: alu_res = ~op_a;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_INC:  alu_res = op_a + {{(DATA_W-1){1'b0}}, 1'b1};
            ALU_PASB: alu_res = op_b;
            ALU_MUL:  alu_res = '0;     // product comes from the multiplier
            default:  alu_res = op_a;   // 1101-1111: PASS A
        endcase
    end

    // ---------------- issue control ----------------
    logic              accept, start_mul, mul_done, commit;
    logic [DATA_W-1:0] mul_product, commit_res;

    assign in_ready  = (state_q == IDLE) && !hazard;
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (alu_op == ALU_MUL);
    assign commit    = (accept && (alu_op != ALU_MUL)) || ((state_q == MUL) && mul_done);
    assign commit_res = (state_q == MUL) ? mul_product : alu_res;

    alu_iter_mul #(.DATA_W(DATA_W)) u_mul (
        .clk_i     (clock),
        .rst_i     (reset),
        .start_i   (start_mul),
        .a_i       (op_a),
        .b_i       (op_b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            mul_rd_q        <= '0;
            mul_rf_write_q  <= 1'b0;
            mul_mem_write_q <= 1'b0;
            mul_mem_sel_q   <= 1'b0;
            mul_store_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state_q)
                IDLE: if (start_mul) begin
                    state_q         <= MUL;
                    mul_rd_q        <= rd_addr;
                    mul_rf_write_q  <= rf_write;
                    mul_mem_write_q <= mem_write;
                    mul_mem_sel_q   <= mem_sel;
                    mul_store_q     <= rt_val;
                end
                MUL:  if (mul_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // EX/WB register and flags: loaded by single-cycle issue or MUL completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_rf_write_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_mem_sel_q   <= 1'b0;
            ex_result_q    <= '0;
            ex_store_q     <= '0;
            zero_q         <= 1'b0;
            pos_q          <= 1'b0;
        end else begin
            ex_valid_q <= commit;
            if (commit) begin
                ex_result_q <= commit_res;
                zero_q      <= (commit_res == '0);
                pos_q       <= !commit_res[DATA_W-1] && (commit_res != '0);
                if (state_q == MUL) begin
                    ex_rd_q        <= mul_rd_q;
                    ex_rf_write_q  <= mul_rf_write_q;
                    ex_mem_write_q <= mul_mem_write_q;
                    ex_mem_sel_q   <= mul_mem_sel_q;
                    ex_store_q     <= mul_store_q;
                end else begin
                    ex_rd_q        <= rd_addr;
                    ex_rf_write_q  <= rf_write;
                    ex_mem_write_q <= mem_write;
                    ex_mem_sel_q   <= mem_sel;
                    ex_store_q     <= rt_val;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_rf_we) begin
            rf_q[ex_rd_q] <= wb_data;
        end
    end

    // NOTE: data memory has no reset so it maps onto RAM; contents are undefined until written.
    always_ff @(posedge clock) begin
        if (ex_valid_q && ex_mem_write_q) mem_q[wb_addr] <= ex_store_q;
    end

    assign zero_flag = zero_q;
    assign pos_flag  = pos_q;
    assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: directed self-checking bench for datapath_pipe.
// Inputs are driven on the falling edge and outputs sampled there, away from
// the active rising edge. Expected values are hand-computed constants.
module tb_datapath_pipe;

    localparam int DW = 16;
    localparam int AW = 3;
`ifdef DATAPATH_FWD_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [AW-1:0] rs_addr, rt_addr, rd_addr, dbg_addr;
    logic [DW-1:0] imm_data, dbg_data;
    logic          imm_sel, rf_write, mem_write, mem_sel;
    logic [3:0]    alu_sel;
    logic          zero_flag, pos_flag;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    datapath_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .imm_data  (imm_data),
        .imm_sel   (imm_sel),
        .alu_sel   (alu_sel),
        .rf_write  (rf_write),
        .mem_write (mem_write),
        .mem_sel   (mem_sel),
        .zero_flag (zero_flag),
        .pos_flag  (pos_flag),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Present one instruction and hold it until accepted; reports stall cycles.
    task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic isel, input logic [DW-1:0] imm,
                         input logic rfw, input logic memw, input logic msel, output int stalls);
        stalls    = 0;
        alu_sel   = op;
        rd_addr   = rd;
        rs_addr   = rs;
        rt_addr   = rt;
        imm_sel   = isel;
        imm_data  = imm;
        rf_write  = rfw;
        mem_write = memw;
        mem_sel   = msel;
        in_valid  = 1'b1;
        #1;
        while (!in_ready && stalls < 40) begin
            stalls++;
            @(negedge clock);
            #1;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reg(input string tag, input logic [AW-1:0] r, input logic [DW-1:0] exp);
        dbg_addr = r;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
        @(negedge clock);
    endtask

    typedef struct packed {
        logic [3:0]    op;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          isel;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp;
    } vec_t;

    // Register state when the table runs: R1=3, R6=FFFE, R7=5.
    vec_t tbl [13] = '{
        '{4'h2, 3'd1, 3'd7, 1'b0, 16'h0000, 16'h0001},  // AND
        '{4'h3, 3'd1, 3'd7, 1'b0, 16'h0000, 16'h0007},  // OR
        '{4'h4, 3'd1, 3'd7, 1'b0, 16'h0000, 16'h0006},  // XOR
        '{4'h5, 3'd1, 3'd0, 1'b0, 16'h0000, 16'hFFFC},  // NOT A
        '{4'h6, 3'd1, 3'd0, 1'b1, 16'h0004, 16'h0030},  // SLL 4
        '{4'h6, 3'd1, 3'd0, 1'b1, 16'h0013, 16'h0018},  // SLL uses low 4 bits only
        '{4'h7, 3'd6, 3'd0, 1'b1, 16'h0001, 16'h7FFF},  // SRL
        '{4'h8, 3'd6, 3'd0, 1'b1, 16'h0001, 16'hFFFF},  // SRA
        '{4'h9, 3'd6, 3'd1, 1'b0, 16'h0000, 16'h0001},  // SLT -2 < 3
        '{4'h9, 3'd1, 3'd6, 1'b0, 16'h0000, 16'h0000},  // SLT 3 < -2
        '{4'hA, 3'd7, 3'd0, 1'b0, 16'h0000, 16'h0006},  // INC
        '{4'hE, 3'd7, 3'd0, 1'b0, 16'h0000, 16'h0005},  // PASS A
        '{4'h0, 3'd6, 3'd0, 1'b1, 16'h0003, 16'h0001}   // ADD wraps
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int busy;
        reset = 1'b1;
        in_valid = 1'b0;
        rs_addr = '0; rt_addr = '0; rd_addr = '0; dbg_addr = '0;
        imm_data = '0; imm_sel = 1'b0; alu_sel = '0;
        rf_write = 1'b0; mem_write = 1'b0; mem_sel = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_zero", 32'(zero_flag), 32'd0);
        check("rst_pos", 32'(pos_flag), 32'd0);
        reset = 1'b0;
        check_reg("rst_r0", 3'd0, 16'h0000);
        check_reg("rst_r7", 3'd7, 16'h0000);

        // MOVI R7,#5 ; MOVI R1,#3 ; ADD R2,R1,R1 (RAW on R1)
        issue(4'hB, 3'd7, 3'd0, 3'd0, 1'b1, 16'd5, 1'b1, 1'b0, 1'b0, st);
        check("movi_stall", 32'(st), 32'd0);
        check("movi_zero", 32'(zero_flag), 32'd0);
        check("movi_pos", 32'(pos_flag), 32'd1);
        issue(4'hB, 3'd1, 3'd0, 3'd0, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0, st);
        issue(4'h0, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, st);
        check("raw_stall", 32'(st), 32'(EXP_STALL));
        check("add_pos", 32'(pos_flag), 32'd1);
        idle(1);
        check_reg("r7_movi", 3'd7, 16'd5);
        check_reg("r1_movi", 3'd1, 16'd3);
        check_reg("r2_add", 3'd2, 16'd6);

        // SUB R3,R1,R1 -> 0 ; SUB R6,R1,#5 -> FFFE
        issue(4'h1, 3'd3, 3'd1, 3'd1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, st);
        check("sub0_zero", 32'(zero_flag), 32'd1);
        check("sub0_pos", 32'(pos_flag), 32'd0);
        issue(4'h1, 3'd6, 3'd1, 3'd0, 1'b1, 16'd5, 1'b1, 1'b0, 1'b0, st);
        check("subn_zero", 32'(zero_flag), 32'd0);
        check("subn_pos", 32'(pos_flag), 32'd0);
        idle(1);
        check_reg("r3_sub", 3'd3, 16'h0000);
        check_reg("r6_sub", 3'd6, 16'hFFFE);

        // Store R7 -> mem[0x10]; load R4 next cycle; ADD R5,R4,R4
        issue(4'hB, 3'd0, 3'd0, 3'd7, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, st);
        check("store_pos", 32'(pos_flag), 32'd1);
        issue(4'hB, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b1, st);
        check("load_stall", 32'(st), 32'd0);
        issue(4'h0, 3'd5, 3'd4, 3'd4, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, st);
        check("load_use_stall", 32'(st), 32'(EXP_STALL));
        idle(1);
        check_reg("r4_load", 3'd4, 16'd5);
        check_reg("r5_add", 3'd5, 16'd10);

        // ALU operation table, results into R5
        foreach (tbl[i]) begin
            issue(tbl[i].op, 3'd5, tbl[i].rs, tbl[i].rt, tbl[i].isel, tbl[i].imm,
                  1'b1, 1'b0, 1'b0, st);
            idle(1);
            check_reg($sformatf("alu_%0d", i), 3'd5, tbl[i].exp);
        end

        // 300 * 300 -> low 16 bits 0x5F90
        issue(4'hB, 3'd1, 3'd0, 3'd0, 1'b1, 16'd300, 1'b1, 1'b0, 1'b0, st);
        issue(4'hB, 3'd2, 3'd0, 3'd0, 1'b1, 16'd300, 1'b1, 1'b0, 1'b0, st);
        issue(4'hC, 3'd6, 3'd1, 3'd2, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, st);
        check("mul_issue_stall", 32'(st), 32'(EXP_STALL));
        busy = 0;
        #1;
        while (!in_ready && busy < 40) begin
            busy++;
            @(negedge clock);
            #1;
        end
        check("mul_busy_cycles", 32'(busy), 32'(DW));
        check("mul_zero", 32'(zero_flag), 32'd0);
        check("mul_pos", 32'(pos_flag), 32'd1);
        @(negedge clock);
        check_reg("r6_mul", 3'd6, 16'h5F90);
        check_reg("r2_pre_mul", 3'd2, 16'd300);

        // Reset during busy cycle 8 of a MUL into R0
        issue(4'hC, 3'd0, 3'd1, 3'd7, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, st);
        repeat (7) @(negedge clock);
        #1;
        check("mul_mid_busy", 32'(in_ready), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_zero", 32'(zero_flag), 32'd0);
        check("mrst_pos", 32'(pos_flag), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle(24);
        for (int r = 0; r < 8; r++) check_reg($sformatf("mrst_r%0d", r), AW'(r), 16'h0000);
        #1;
        check("mrst_ready_after", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
Parametrised successor to the single-cycle 16-bit datapath. It keeps the register file, the ALU (including alu_sel 4'b1011 = PASS B for MOVI), the imm_sel operand mux, the data memory and the mem_sel write-back mux. It adds the following:
- a two-stage EX/WB pipeline with a valid/ready issue handshake;
- RAW forwarding;
- an iterative multi-cycle multiplier;
- a generic debug read port that replaces the fixed r7_data.

It sits between the control unit/decoder and the register/memory state.

Parameters:
DATA_W, 16, datapath word width (>=8).
NREGS, 8, register count (power of 2); ADDR_W = $clog2(NREGS) is a derived localparam.
MEM_DEPTH, 256, data memory words; memory address = ALU result [$clog2(MEM_DEPTH)-1:0].

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  decoded instruction present.
in_ready  out  1  datapath can accept; transfer occurs when in_valid && in_ready.
rs_addr  in  ADDR_W  operand A register.
rt_addr  in  ADDR_W  operand B register / store data register.
rd_addr  in  ADDR_W  destination register.
imm_data  in  DATA_W  immediate.
imm_sel  in  1  1: B = imm_data; 0: B = RF[rt].
alu_sel  in  4  ALU operation.
rf_write  in  1  write rd at WB.
mem_write  in  1  store RF[rt] to mem[ALU result] at WB.
mem_sel  in  1  1: rd <= mem[ALU result]; 0: rd <= ALU result.
zero_flag  out  1  last result == 0.
pos_flag  out  1  last result signed > 0.
dbg_addr  in  ADDR_W  debug register select.
dbg_data  out  DATA_W  RF[dbg_addr], combinational read of committed state.

Behaviour:
Reset:
- Clears all RF registers, EX/WB pipeline registers (valid=0), zero_flag, pos_flag and the FSM (to IDLE). in_ready=1.
- Memory contents are not reset.
- Reset mid-multiply abandons the operation; no write-back occurs.

ALU operations:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A.
- 0110 SLL A by B[$clog2(DATA_W)-1:0], 0111 SRL, 1000 SRA.
- 1001 SLT signed (result 1/0), 1010 INC A, 1011 PASS B, 1100 MUL (low DATA_W bits), 1101-1111 PASS A.
- All arithmetic is modulo 2^DATA_W; carries are discarded.

Timing for an accept at edge N (single-cycle op):
- Operands are read combinationally and the ALU result is latched into EX/WB at edge N.
- zero_flag/pos_flag update at edge N.
- At edge N+1, WB performs the RF write (rd, if rf_write) and the memory store (if mem_write). Both may occur in the same instruction.
- Load data is read combinationally from memory in WB.
- dbg_data shows the new value after edge N+1.

Flags:
- Updated for every accepted instruction, including stores.
- pos = !result[DATA_W-1] && result != 0.

Forwarding:
- If an issuing rs or rt matches the WB rd with rf_write and WB valid, the WB write-data (ALU or memory) replaces the RF read.
- The RF itself has no internal write-through.

FSM (IDLE, MUL):
- IDLE: in_ready=1. Accepting alu_sel=1100 latches operands and moves to MUL; nothing enters EX/WB that edge.
- MUL: shift-add, one bit per cycle. in_ready=0 for exactly DATA_W cycles. The result enters EX/WB (and flags update) on the edge ending the last busy cycle; the FSM then returns to IDLE.
- The instruction preceding MUL still completes WB normally.

Other rules:
- Store-then-load to the same address in consecutive cycles returns the stored data with no hazard.
- in_valid=0 inserts a bubble (EX/WB valid=0, no writes).

Optional Feature:
DATAPATH_FWD_EN
- Defined: forwarding as above; in_ready stays 1 on RAW hazards.
- Undefined: no bypass. On a RAW hazard against WB, in_ready drops for one cycle (interlock) and the instruction is accepted the next cycle.
- Architectural results are identical in both cases; only the cycle count differs.

Decomposition:
- Package datapath_pkg:
  - alu_op_e enum (4-bit codes above);
  - fsm_state_e {IDLE, MUL};
  - default width constants.
- One sub-module: alu_iter_mul (start/done iterative multiplier, parametrised by DATA_W).
- The combinational ALU and the RF stay inline.

Test Plan:
1. MOVI R7,#5 (imm_sel=1, imm_data=5, alu_sel=1011, rd=7, rf_write=1) -> dbg_addr=7 reads 16'd5 after second edge; zero=0, pos=1.
2. MOVI R1,#3 then ADD R2,R1,R1 back-to-back -> R2=6. With FWD_EN: in_ready stays 1. Without: in_ready=0 exactly one cycle, same R2.
3. SUB R3,R1,R1 -> R3=0, zero=1, pos=0. Then SUB R1 minus imm 5 -> 16'hFFFE, zero=0, pos=0.
4. Store R7 (5) to address 0x10 (alu_sel=1011, imm=0x10, rt=7, mem_write=1), next cycle load R4 from 0x10 (mem_sel=1) -> R4=5. Following ADD R5,R4,R4 forwards -> R5=10.
5. R1=300, R2=300, MUL R6 -> in_ready=0 for 16 cycles; R6=16'h5F90; pos=1.
6. Assert reset during cycle 8 of MUL -> in_ready=1 immediately, flags=0, all dbg reads 0, R6 never written.
